iq_capture_hls_deadlock_report_ctrl: RTL and testbench
======================================================

// Module: iq_capture_hls_deadlock_report_ctrl
// PURPOSE
// Central controller for the per-process deadlock detection units. Watches every unit's
// dl_detect_out and confirms a persistent detection. Elects one unit as token origin and
// tracks the token around the dependency cycle. Clears the token when it returns, then
// presents a single handshaked report: origin ID, cycle members, timeout flag.
// PARAMETERS
// PROC_NUM        4   number of detection units/processes (>=2); ID_W = $clog2(PROC_NUM)
// CONFIRM_CYCLES  4   consecutive cycles dl_detect_vec must be nonzero before election (>=1)
// TRACE_TIMEOUT   64  max cycles from origin pulse to token return before abort (>=2)
// PORTS
// clock            in   1         rising-edge clock
// reset            in   1         asynchronous, active-low reset
// dl_detect_vec    in   PROC_NUM  bit i = dl_detect_out of unit i
// token_ret_vec    in   PROC_NUM  bit i = OR of unit i token_in_vec (token present at i)
// origin_vec       out  PROC_NUM  one-hot, 1-cycle pulse to elected unit's origin input
// token_clear_vec  out  PROC_NUM  one-hot, 1-cycle pulse to elected unit's token_clear
// dl_detect_global out  1         sticky: set at first election, cleared only by reset
// report_valid     out  1         report available; held until accepted
// report_ready     in   1         consumer accepts report when valid & ready
// report_origin    out  ID_W      index of elected origin unit
// report_members   out  PROC_NUM  units that saw the token during trace (origin included)
// report_timeout   out  1         1 = token did not return within TRACE_TIMEOUT
// report_count     out  8         accepted reports, saturates at 255
// BEHAVIOUR
// Reset (reset=0, async): state=IDLE; every output and counter 0; takes effect mid-trace.
// States: IDLE -> ORIGIN -> TRACE -> REPORT -> IDLE.
// IDLE:
//  - confirm_cnt increments each cycle |dl_detect_vec=1; a zero cycle clears it to 0.
//  - When |dl_detect_vec=1 and confirm_cnt==CONFIRM_CYCLES-1: latch origin_id = lowest set
//    bit of dl_detect_vec in that cycle; clear members, trace_cnt, timeout; go to ORIGIN.
//  - CONFIRM_CYCLES=1 elects in the first cycle detection is seen.
// ORIGIN (1 cycle):
//  - origin_vec = 1<<origin_id; set dl_detect_global; go to TRACE.
// TRACE:
//  - members |= token_ret_vec every cycle; trace_cnt increments from 0.
//  - token_ret_vec[origin_id]=1: token_clear_vec = 1<<origin_id in the same cycle; go to
//    REPORT (timeout=0). Members include that cycle's token_ret_vec.
//  - Else trace_cnt==TRACE_TIMEOUT-1: timeout=1; go to REPORT; no token_clear pulse.
//  - Return and timeout in the same cycle: return wins (timeout=0).
// REPORT:
//  - report_valid=1; report_origin, report_members, report_timeout stable while waiting.
//  - report_valid & report_ready: report_count+=1 (saturating); go to IDLE with
//    confirm_cnt=0, so a re-election needs a fresh CONFIRM_CYCLES window.
//  - dl_detect_vec and token_ret_vec are ignored outside IDLE and TRACE respectively.
// Outputs: origin_vec and token_clear_vec are registered, never more than one bit set,
// and never asserted in the same cycle. Report fields keep their last value in IDLE;
// report_valid is low outside REPORT.
// Latency: election to origin pulse = 1 cycle. Token clear coincides with the return cycle.
// TESTING
// T1 PROC_NUM=4, CONFIRM=4: dl_detect_vec=4'b0110 for 4 cycles -> origin_vec=4'b0010
//    pulse next cycle; dl_detect_global=1.
// T2 dl_detect_vec nonzero 3 cycles, 0 for 1 cycle, nonzero 3 cycles -> no origin pulse.
// T3 After origin=1: token_ret_vec 4'b0100, then 4'b1000, then 4'b0010 ->
//    token_clear_vec=4'b0010 in return cycle; report members=4'b1110, origin=1, timeout=0.
// T4 TRACE_TIMEOUT=64, token never returns -> REPORT after 64 TRACE cycles, timeout=1,
//    no token_clear pulse.
// T5 report_ready=0 for 10 cycles -> report_valid and fields stable; ready=1 ->
//    report_count 0->1, state IDLE.
// T6 reset pulsed low mid-TRACE -> all outputs 0 immediately; dl_detect_global=0.

Source files
------------

// File: rtl/iq_capture_hls_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : iq_capture_hls_deadlock_report_ctrl
//  Description : Central deadlock report controller. Confirms a persistent
//                detection from the per-process units, elects the lowest
//                detecting unit as token origin, follows the token around the
//                dependency cycle and presents one handshaked report (origin,
//                cycle members, timeout flag).
//  Revision    : 1.0  initial release
// ============================================================================
module iq_capture_hls_deadlock_report_ctrl #(
   parameter int PROC_NUM       = 4,
   parameter int CONFIRM_CYCLES = 4,
   parameter int TRACE_TIMEOUT  = 64,
   localparam int ID_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_detect_vec,
   input  logic [PROC_NUM-1:0] token_ret_vec,
   output logic [PROC_NUM-1:0] origin_vec,
   output logic [PROC_NUM-1:0] token_clear_vec,
   output logic                dl_detect_global,
   output logic                report_valid,
   input  logic                report_ready,
   output logic [ID_W-1:0]     report_origin,
   output logic [PROC_NUM-1:0] report_members,
   output logic                report_timeout,
   output logic [7:0]          report_count
);

   localparam int c_CNF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES + 1) : 1;
   localparam int c_TR_W  = $clog2(TRACE_TIMEOUT);

   localparam logic [c_CNF_W-1:0]  c_CNF_LAST = c_CNF_W'(CONFIRM_CYCLES - 1);
   localparam logic [c_TR_W-1:0]   c_TR_LAST  = c_TR_W'(TRACE_TIMEOUT - 1);
   localparam logic [PROC_NUM-1:0] c_ONE      = {{(PROC_NUM-1){1'b0}}, 1'b1};

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_ORIGIN = 2'd1;
   localparam logic [1:0] c_ST_TRACE  = 2'd2;
   localparam logic [1:0] c_ST_REPORT = 2'd3;

   logic [1:0]          r_state;
   logic [c_CNF_W-1:0]  r_confirm_cnt;
   logic [c_TR_W-1:0]   r_trace_cnt;
   logic [ID_W-1:0]     r_origin_id;
   logic [PROC_NUM-1:0] r_members;
   logic                r_timeout;
   logic [PROC_NUM-1:0] r_origin_pulse;
   logic [PROC_NUM-1:0] r_clear_pulse;
   logic                r_global;
   logic [7:0]          r_report_count;

   logic [ID_W-1:0]     w_low_id;
   logic                w_any_detect;
   logic                w_token_home;

   // Priority encoder: lowest-numbered detecting unit becomes the origin.
   always_comb begin
      w_low_id = '0;
      for (int i = PROC_NUM - 1; i >= 0; i--) begin
         if (dl_detect_vec[i]) begin
            w_low_id = ID_W'(i);
         end
      end
   end

   assign w_any_detect = |dl_detect_vec;
   assign w_token_home = token_ret_vec[r_origin_id];

   // Controller state machine with its confirm/trace counters and report fields.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= c_ST_IDLE;
         r_confirm_cnt  <= '0;
         r_trace_cnt    <= '0;
         r_origin_id    <= '0;
         r_members      <= '0;
         r_timeout      <= 1'b0;
         r_origin_pulse <= '0;
         r_clear_pulse  <= '0;
         r_global       <= 1'b0;
         r_report_count <= '0;
      end else begin
         // Pulses last exactly one cycle unless re-armed below.
         r_origin_pulse <= '0;
         r_clear_pulse  <= '0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_any_detect) begin
                  if (r_confirm_cnt == c_CNF_LAST) begin
                     r_origin_id    <= w_low_id;
                     r_members      <= '0;
                     r_trace_cnt    <= '0;
                     r_timeout      <= 1'b0;
                     r_confirm_cnt  <= '0;
                     r_origin_pulse <= c_ONE << w_low_id;
                     r_global       <= 1'b1;
                     r_state        <= c_ST_ORIGIN;
                  end else begin
                     r_confirm_cnt <= r_confirm_cnt + c_CNF_W'(1);
                  end
               end else begin
                  r_confirm_cnt <= '0;
               end
            end
            c_ST_ORIGIN: begin
               r_state <= c_ST_TRACE;
            end
            c_ST_TRACE: begin
               r_members <= r_members | token_ret_vec;
               if (w_token_home) begin
                  // A return on the last allowed cycle still counts as a return.
                  r_clear_pulse <= c_ONE << r_origin_id;
                  r_timeout     <= 1'b0;
                  r_state       <= c_ST_REPORT;
               end else if (r_trace_cnt == c_TR_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= c_ST_REPORT;
               end else begin
                  r_trace_cnt <= r_trace_cnt + c_TR_W'(1);
               end
            end
            c_ST_REPORT: begin
               if (report_ready) begin
                  if (r_report_count != 8'hFF) begin
                     r_report_count <= r_report_count + 8'd1;
                  end
                  r_confirm_cnt <= '0;
                  r_state       <= c_ST_IDLE;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign origin_vec       = r_origin_pulse;
   assign token_clear_vec  = r_clear_pulse;
   assign dl_detect_global = r_global;
   assign report_valid     = (r_state == c_ST_REPORT);
   assign report_origin    = r_origin_id;
   assign report_members   = r_members;
   assign report_timeout   = r_timeout;
   assign report_count     = r_report_count;

endmodule
`default_nettype wire

// File: tb/tb_iq_capture_hls_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_capture_hls_deadlock_report_ctrl
//  Description : Self-checking bench for the deadlock report controller with
//                randomized detection/token patterns and a scenario-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iq_capture_hls_deadlock_report_ctrl;

   localparam int PROC_NUM = 4;
   localparam int CONF     = 4;
   localparam int TMO      = 64;

   logic       clock;
   logic       reset;
   logic [3:0] dl_detect_vec;
   logic [3:0] token_ret_vec;
   logic [3:0] origin_vec;
   logic [3:0] token_clear_vec;
   logic       dl_detect_global;
   logic       report_valid;
   logic       report_ready;
   logic [1:0] report_origin;
   logic [3:0] report_members;
   logic       report_timeout;
   logic [7:0] report_count;

   int vectors    = 0;
   int miscompares = 0;
   int exp_count  = 0;

   iq_capture_hls_deadlock_report_ctrl #(
      .PROC_NUM       (PROC_NUM),
      .CONFIRM_CYCLES (CONF),
      .TRACE_TIMEOUT  (TMO)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .dl_detect_vec    (dl_detect_vec),
      .token_ret_vec    (token_ret_vec),
      .origin_vec       (origin_vec),
      .token_clear_vec  (token_clear_vec),
      .dl_detect_global (dl_detect_global),
      .report_valid     (report_valid),
      .report_ready     (report_ready),
      .report_origin    (report_origin),
      .report_members   (report_members),
      .report_timeout   (report_timeout),
      .report_count     (report_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [3:0] rand_nz();
      return 4'($urandom_range(1, 15));
   endfunction

   // Hold random nonzero detections for a full confirm window and check the election.
   task automatic do_election(output int id);
      logic [3:0] v;
      v = 4'b0001;
      for (int c = 0; c < CONF; c++) begin
         v = rand_nz();
         dl_detect_vec = v;
         step();
         if (c < CONF - 1) begin
            vectors++;
            if (origin_vec !== 4'b0000) begin
               miscompares++;
               $display("FAIL early_origin: origin_vec=%b required 0000 (cycle %0d)", origin_vec, c);
            end
         end
      end
      id = lowest(v);
      vectors++;
      if (origin_vec !== (4'b0001 << id)) begin
         miscompares++;
         $display("FAIL origin_pulse: origin_vec=%b required %b", origin_vec, 4'b0001 << id);
      end
      vectors++;
      if (dl_detect_global !== 1'b1) begin
         miscompares++;
         $display("FAIL global_set: dl_detect_global=%b required 1", dl_detect_global);
      end
      dl_detect_vec = 4'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      dl_detect_vec = '0;
      token_ret_vec = '0;
      report_ready  = 1'b0;
      step();
      step();
      vectors++;
      if ({origin_vec, token_clear_vec, dl_detect_global, report_valid, report_origin,
           report_members, report_timeout, report_count} !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_state: outputs=%h required 000000",
                  {origin_vec, token_clear_vec, dl_detect_global, report_valid, report_origin,
                   report_members, report_timeout, report_count});
      end
      reset = 1'b1;
      step();
   endtask

   // Confirm window broken by a single zero cycle must never elect.
   task automatic test_confirm_break();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < CONF - 1; c++) begin
            dl_detect_vec = rand_nz();
            step();
            vectors++;
            if (origin_vec !== 4'b0000 || dl_detect_global !== 1'b0) begin
               miscompares++;
               $display("FAIL confirm_break: origin_vec=%b global=%b required 0000/0",
                        origin_vec, dl_detect_global);
            end
         end
         dl_detect_vec = '0;
         step();
         vectors++;
         if (origin_vec !== 4'b0000) begin
            miscompares++;
            $display("FAIL confirm_break_zero: origin_vec=%b required 0000", origin_vec);
         end
      end
   endtask

   // Token travels a random path then returns; report held under back-pressure.
   task automatic test_token_return(input int rounds);
      int id;
      int n;
      int hold;
      logic [3:0] exp_members;
      logic [3:0] t;
      for (int r = 0; r < rounds; r++) begin
         do_election(id);
         token_ret_vec = 4'($urandom);        // ORIGIN cycle: ignored
         step();
         vectors++;
         if (origin_vec !== 4'b0000 || report_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL origin_one_cycle: origin_vec=%b valid=%b required 0000/0",
                     origin_vec, report_valid);
         end
         exp_members = '0;
         n = $urandom_range(0, 20);
         for (int k = 0; k < n; k++) begin
            t = 4'($urandom) & ~(4'b0001 << id);
            exp_members |= t;
            token_ret_vec = t;
            step();
            vectors++;
            if (token_clear_vec !== 4'b0000 || report_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL trace_quiet: clear=%b valid=%b required 0000/0",
                        token_clear_vec, report_valid);
            end
         end
         t = 4'($urandom) | (4'b0001 << id);
         exp_members |= t;
         token_ret_vec = t;
         step();
         vectors++;
         if (token_clear_vec !== (4'b0001 << id)) begin
            miscompares++;
            $display("FAIL token_clear: clear=%b required %b", token_clear_vec, 4'b0001 << id);
         end
         vectors++;
         if (report_valid !== 1'b1 || report_origin !== 2'(id) || report_members !== exp_members
             || report_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL report_fields: valid=%b origin=%0d members=%b tmo=%b required 1/%0d/%b/0",
                     report_valid, report_origin, report_members, report_timeout, id, exp_members);
         end
         hold = (r == 0) ? 10 : $urandom_range(0, 5);
         report_ready = 1'b0;
         for (int h = 0; h < hold; h++) begin
            token_ret_vec = 4'($urandom);
            dl_detect_vec = 4'($urandom);
            step();
            vectors++;
            if (report_valid !== 1'b1 || report_origin !== 2'(id) || report_members !== exp_members
                || report_timeout !== 1'b0 || token_clear_vec !== 4'b0000
                || report_count !== 8'(exp_count)) begin
               miscompares++;
               $display("FAIL report_hold: valid=%b origin=%0d members=%b clear=%b count=%0d required 1/%0d/%b/0000/%0d",
                        report_valid, report_origin, report_members, token_clear_vec, report_count,
                        id, exp_members, exp_count);
            end
         end
         dl_detect_vec = '0;
         report_ready = 1'b1;
         step();
         exp_count = (exp_count < 255) ? exp_count + 1 : 255;
         report_ready = 1'b0;
         vectors++;
         if (report_valid !== 1'b0 || report_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL accept: valid=%b count=%0d required 0/%0d", report_valid, report_count, exp_count);
         end
         step();
         vectors++;
         if (report_origin !== 2'(id) || report_members !== exp_members || origin_vec !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_retain: origin=%0d members=%b origin_vec=%b required %0d/%b/0000",
                     report_origin, report_members, origin_vec, id, exp_members);
         end
      end
   endtask

   // Token never returns (ret_at<0) or returns on the last allowed trace cycle.
   task automatic test_timeout(input int ret_at);
      int id;
      logic [3:0] exp_members;
      logic [3:0] t;
      logic       exp_tmo;
      do_election(id);
      token_ret_vec = '0;
      step();
      exp_members = '0;
      for (int k = 0; k < TMO; k++) begin
         t = 4'($urandom) & ~(4'b0001 << id);
         if (k == ret_at) t |= (4'b0001 << id);
         exp_members |= t;
         token_ret_vec = t;
         step();
         if (k < TMO - 1) begin
            vectors++;
            if (report_valid !== 1'b0 || token_clear_vec !== 4'b0000) begin
               miscompares++;
               $display("FAIL timeout_early: valid=%b clear=%b at trace cycle %0d required 0/0000",
                        report_valid, token_clear_vec, k);
            end
         end
      end
      exp_tmo = (ret_at < 0);
      vectors++;
      if (report_valid !== 1'b1 || report_timeout !== exp_tmo || report_members !== exp_members
          || report_origin !== 2'(id)) begin
         miscompares++;
         $display("FAIL timeout_report: valid=%b tmo=%b members=%b origin=%0d required 1/%b/%b/%0d",
                  report_valid, report_timeout, report_members, report_origin, exp_tmo, exp_members, id);
      end
      vectors++;
      if (token_clear_vec !== (exp_tmo ? 4'b0000 : (4'b0001 << id))) begin
         miscompares++;
         $display("FAIL timeout_clear: clear=%b required %b", token_clear_vec,
                  exp_tmo ? 4'b0000 : (4'b0001 << id));
      end
      dl_detect_vec = '0;
      report_ready = 1'b1;
      step();
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      report_ready = 1'b0;
   endtask

   // Detection held through REPORT: re-election needs a fresh full window in IDLE.
   task automatic test_reelection();
      int id;
      logic [3:0] v;
      do_election(id);
      token_ret_vec = '0;
      step();
      token_ret_vec = 4'b0001 << id;
      step();
      v = rand_nz();
      dl_detect_vec = v;
      report_ready = 1'b1;
      step();
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      report_ready = 1'b0;
      for (int c = 0; c < CONF; c++) begin
         step();
         vectors++;
         if (origin_vec !== ((c == CONF - 1) ? (4'b0001 << lowest(v)) : 4'b0000)) begin
            miscompares++;
            $display("FAIL reelect_window: origin_vec=%b at idle cycle %0d required %b", origin_vec, c,
                     (c == CONF - 1) ? (4'b0001 << lowest(v)) : 4'b0000);
         end
      end
      step();
      token_ret_vec = 4'b0001 << lowest(v);
      step();
      dl_detect_vec = '0;
      report_ready = 1'b1;
      step();
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      report_ready = 1'b0;
   endtask

   // Fast back-to-back reports drive report_count into saturation.
   task automatic test_back_to_back();
      int id;
      while (exp_count < 258) begin
         do_election(id);
         token_ret_vec = '0;
         step();
         token_ret_vec = 4'b0001 << id;
         step();
         dl_detect_vec = '0;
         report_ready = 1'b1;
         step();
         report_ready = 1'b0;
         exp_count++;
         vectors++;
         if (report_count !== 8'((exp_count > 255) ? 255 : exp_count)) begin
            miscompares++;
            $display("FAIL count_sat: count=%0d required %0d", report_count,
                     (exp_count > 255) ? 255 : exp_count);
         end
      end
      exp_count = 255;
   endtask

   // Asynchronous reset asserted between clock edges in the middle of a trace.
   task automatic test_reset_mid_trace();
      int id;
      do_election(id);
      token_ret_vec = '0;
      step();
      for (int k = 0; k < 5; k++) begin
         token_ret_vec = 4'($urandom) & ~(4'b0001 << id);
         step();
      end
      #1;
      reset = 1'b0;
      #1;
      vectors++;
      if ({origin_vec, token_clear_vec, dl_detect_global, report_valid, report_origin,
           report_members, report_timeout, report_count} !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_async: outputs=%h required 000000",
                  {origin_vec, token_clear_vec, dl_detect_global, report_valid, report_origin,
                   report_members, report_timeout, report_count});
      end
      token_ret_vec = '0;
      dl_detect_vec = '0;
      step();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++;
         if (origin_vec !== 4'b0000 || report_valid !== 1'b0 || dl_detect_global !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: origin_vec=%b valid=%b global=%b required 0000/0/0",
                     origin_vec, report_valid, dl_detect_global);
         end
      end
   endtask

   initial begin
      test_reset();
      test_confirm_break();
      test_token_return(6);
      test_timeout(-1);
      test_timeout(TMO - 1);
      test_reelection();
      test_back_to_back();
      test_reset_mid_trace();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
